// File: rtl/pt2272_frame_controller.sv
// ---------------------------------------------------------------------------
// pt2272_frame_controller : PT2272 frame aligner, address check, N-frame confirm.
// Optional macro PT2272_MOMENTARY_EN clears D on timeout/sym_err.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pt2272_frame_controller #(
  parameter int CONFIRM_FRAMES = 2,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_i,
  input  logic        sym_valid,
  input  logic [1:0]  sym,
  input  logic        sym_err,
  output logic [3:0]  D,
  output logic        dv,
  output logic        frame_ok,
  output logic        frame_err
);

  localparam logic [1:0]  SYM_SYNC = 2'b01;
  localparam logic [2:0]  CONF_MAX = 3'(CONFIRM_FRAMES);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {HUNT, COLLECT, WAIT_SYNC, EVAL} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [23:0] frame_q, frame_d;
  logic [2:0]  conf_q, conf_d;
  logic [15:0] tmo_q, tmo_d;
  logic [3:0]  prev_q, prev_d;
  logic [3:0]  d_q, d_d;
  logic        dv_q, dv_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;

  logic        sym_ok;
  logic        is_sync;
  logic        timeout;
  logic        drop;
  logic        addr_match;
  logic        data_legal;
  logic [3:0]  frame_data;

  assign sym_ok  = sym_valid & ~sym_err;
  assign is_sync = (sym == SYM_SYNC);
  assign timeout = ((state_q == COLLECT) || (state_q == WAIT_SYNC)) &&
                   !sym_valid && !sym_err && (tmo_q >= TMO_LAST);
  assign addr_match = (frame_q[15:0] == addr_i);

  // Data trits are legal only as 00 or 11, so either bit of the code gives the data bit.
  always_comb begin
    data_legal = 1'b1;
    frame_data = 4'd0;
    for (int i = 0; i < 4; i++) begin
      data_legal     = data_legal & (frame_q[16 + 2*i] == frame_q[17 + 2*i]);
      frame_data[3-i] = frame_q[16 + 2*i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    conf_d  = conf_q;
    prev_d  = prev_q;
    d_d     = d_q;
    dv_d    = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    drop    = 1'b0;
    tmo_d   = (sym_valid || sym_err || (state_q == HUNT)) ? 16'd0 : tmo_q + 16'd1;

    case (state_q)
      HUNT: begin
        if (sym_ok && is_sync) begin
          state_d = COLLECT;
          idx_d   = 4'd0;
        end
      end
      COLLECT: begin
        if (sym_err) begin
          err_d = 1'b1;
          drop  = 1'b1;
        end else if (timeout) begin
          drop = 1'b1;
        end else if (sym_valid) begin
          if (is_sync) begin
            err_d = 1'b1;
            idx_d = 4'd0;
          end else begin
            frame_d[{idx_q, 1'b0} +: 2] = sym;
            if (idx_q == 4'd11) begin
              state_d = WAIT_SYNC;
              idx_d   = 4'd0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
      WAIT_SYNC: begin
        if (sym_err) begin
          err_d = 1'b1;
          drop  = 1'b1;
        end else if (timeout) begin
          drop = 1'b1;
        end else if (sym_valid) begin
          if (is_sync) begin
            state_d = EVAL;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
            conf_d  = 3'd0;
          end
        end
      end
      EVAL: begin
        state_d = COLLECT;
        idx_d   = 4'd0;
        if (addr_match && data_legal) begin
          ok_d   = 1'b1;
          prev_d = frame_data;
          if (frame_data == prev_q)
            conf_d = (conf_q >= CONF_MAX) ? CONF_MAX : conf_q + 3'd1;
          else
            conf_d = 3'd1;
          // A distinct value reaching the threshold must publish even when CONFIRM_FRAMES is 1.
          if ((conf_d == CONF_MAX) && ((conf_q < CONF_MAX) || (frame_data != prev_q))) begin
            dv_d = 1'b1;
            d_d  = frame_data;
          end
        end else begin
          err_d  = 1'b1;
          conf_d = 3'd0;
        end
      end
      default: state_d = HUNT;
    endcase

    if (drop) begin
      state_d = HUNT;
      idx_d   = 4'd0;
      conf_d  = 3'd0;
`ifdef PT2272_MOMENTARY_EN
      d_d     = 4'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      idx_q   <= 4'd0;
      frame_q <= 24'd0;
      conf_q  <= 3'd0;
      tmo_q   <= 16'd0;
      prev_q  <= 4'd0;
      d_q     <= 4'd0;
      dv_q    <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      conf_q  <= conf_d;
      tmo_q   <= tmo_d;
      prev_q  <= prev_d;
      d_q     <= d_d;
      dv_q    <= dv_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign D         = d_q;
  assign dv        = dv_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pt2272_frame_controller.sv
// ---------------------------------------------------------------------------
// tb_pt2272_frame_controller : directed + randomized bench with frame-level model.
// Honours PT2272_MOMENTARY_EN the same way as the design.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pt2272_frame_controller;

  localparam int CONF = 2;
  localparam int TMO  = 300;
  localparam logic [1:0] SYNC = 2'b01;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr_i;
  logic        sym_valid;
  logic [1:0]  sym;
  logic        sym_err;
  logic [3:0]  D;
  logic        dv;
  logic        frame_ok;
  logic        frame_err;

  pt2272_frame_controller #(.CONFIRM_FRAMES(CONF), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .addr_i(addr_i), .sym_valid(sym_valid), .sym(sym),
    .sym_err(sym_err), .D(D), .dv(dv), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse counters sampled on the falling edge.
  int n_ok = 0, n_err = 0, n_dv = 0;
  logic [3:0] d_at_dv = 4'd0;
  always @(negedge clk) begin
    if (frame_ok)  n_ok++;
    if (frame_err) n_err++;
    if (dv) begin
      n_dv++;
      d_at_dv = D;
    end
  end

  // Frame-level reference model.
  bit         m_in_frame = 0;
  logic [1:0] m_q[$];
  int         m_run = 0;
  logic [3:0] m_prev = 4'd0;
  logic [3:0] m_D = 4'd0;
  logic [15:0] m_addr;
  int e_ok = 0, e_err = 0, e_dv = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_abandon();
    if (m_in_frame) begin
      m_in_frame = 0;
      m_run = 0;
`ifdef PT2272_MOMENTARY_EN
      m_D = 4'd0;
`endif
    end
  endtask

  task automatic model_eval();
    bit good = 1;
    logic [3:0] data = 4'd0;
    for (int i = 0; i < 8; i++)
      if (m_q[i] != m_addr[2*i +: 2]) good = 0;
    for (int i = 8; i < 12; i++) begin
      if (m_q[i] != 2'b00 && m_q[i] != 2'b11) good = 0;
      data[11-i] = (m_q[i] == 2'b11);
    end
    if (good) begin
      e_ok++;
      m_run = (data == m_prev) ? m_run + 1 : 1;
      m_prev = data;
      if (m_run == CONF) begin
        e_dv++;
        m_D = data;
      end
    end else begin
      e_err++;
      m_run = 0;
    end
  endtask

  task automatic model_sym(logic [1:0] s, bit err, bit val);
    if (err) begin
      if (m_in_frame) e_err++;
      model_abandon();
    end else if (val) begin
      if (!m_in_frame) begin
        if (s == SYNC) begin
          m_in_frame = 1;
          m_q.delete();
        end
      end else if (m_q.size() < 12) begin
        if (s == SYNC) begin
          e_err++;
          m_q.delete();
        end else begin
          m_q.push_back(s);
        end
      end else if (s == SYNC) begin
        model_eval();
        m_q.delete();
      end else begin
        e_err++;
        m_in_frame = 0;
        m_run = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0;
    m_q.delete();
    m_run = 0;
    m_prev = 4'd0;
    m_D = 4'd0;
  endtask

  task automatic compare(string tag, int dv_before);
    chk({tag, "_ok"},  n_ok,  e_ok);
    chk({tag, "_err"}, n_err, e_err);
    chk({tag, "_dv"},  n_dv,  e_dv);
    chk({tag, "_D"},   D,     m_D);
    if (n_dv != dv_before) chk({tag, "_D_at_dv"}, d_at_dv, m_D);
  endtask

  task automatic send_sym(logic [1:0] s, bit err = 0, bit val = 1);
    int dv_before = n_dv;
    @(negedge clk);
    sym_valid = val;
    sym       = s;
    sym_err   = err;
    @(negedge clk);
    sym_valid = 1'b0;
    sym_err   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    model_sym(s, err, val);
    compare("sym", dv_before);
  endtask

  task automatic send_trits(logic [23:0] f, int first, int last);
    for (int i = first; i <= last; i++) send_sym(f[2*i +: 2]);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [23:0] mk_frame(logic [15:0] a, logic [3:0] d);
    return {{2{d[0]}}, {2{d[1]}}, {2{d[2]}}, {2{d[3]}}, a};
  endfunction

  function automatic logic [1:0] rtrit();
    case ($urandom_range(2))
      0:       return 2'b00;
      1:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] fa, fb, f;
    logic [15:0] a;
    logic [3:0]  rd;
    logic [1:0]  t, nt;
    int kind, pos;

    reset = 1'b1; sym_valid = 1'b0; sym = 2'b00; sym_err = 1'b0;
    addr_i = 16'hAAAA; m_addr = 16'hAAAA;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_D", D, 4'd0);
    chk("rst_dv", dv, 1'b0);
    chk("rst_ok", frame_ok, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    reset = 1'b0;

    // Two identical frames confirm 1011.
    fa = mk_frame(16'hAAAA, 4'b1011);
    send_sym(SYNC);
    send_trits(fa, 0, 11); send_sym(SYNC);
    send_trits(fa, 0, 11); send_sym(SYNC);
    chk("confirm_D", D, 4'b1011);
    chk("confirm_dv_once", n_dv, 1);
    chk("confirm_ok_twice", n_ok, 2);

    // Third identical frame: no new dv; then 0110 twice.
    send_trits(fa, 0, 11); send_sym(SYNC);
    chk("third_no_dv", n_dv, 1);
    fb = mk_frame(16'hAAAA, 4'b0110);
    send_trits(fb, 0, 11); send_sym(SYNC);
    send_trits(fb, 0, 11); send_sym(SYNC);
    chk("requal_D", D, 4'b0110);
    chk("requal_dv", n_dv, 2);

    // Address trit 3 sent as 0 against F.
    f = fb; f[7:6] = 2'b00;
    send_trits(f, 0, 11); send_sym(SYNC);
    send_trits(fb, 0, 11); send_sym(SYNC);
    chk("restart_no_dv", n_dv, 2);
    send_trits(fb, 0, 11); send_sym(SYNC);
    chk("restart_dv", n_dv, 3);

    // Early sync after 5 trits, then a normal frame, then a data trit F.
    send_trits(fa, 0, 4); send_sym(SYNC);
    send_trits(fa, 0, 11); send_sym(SYNC);
    f = fa; f[19:18] = 2'b10;
    send_trits(f, 0, 11); send_sym(SYNC);
    chk("dataF_hold_D", D, 4'b0110);

    // Re-confirm 1011, then check timeout boundary both sides.
    send_trits(fa, 0, 11); send_sym(SYNC);
    send_trits(fa, 0, 11); send_sym(SYNC);
    send_trits(fa, 0, 3);
    idle(TMO - 20);
    send_trits(fa, 4, 11); send_sym(SYNC);
    chk("pre_timeout_D", D, 4'b1011);
    idle(TMO + 4);
    model_abandon();
    compare("timeout", n_dv);
`ifdef PT2272_MOMENTARY_EN
    chk("timeout_D", D, 4'b0000);
`else
    chk("timeout_D", D, 4'b1011);
`endif
    send_trits(fa, 0, 11);
    send_sym(SYNC);
    send_sym(2'b11, 1'b1, 1'b1);
    send_sym(SYNC);
    send_trits(fa, 0, 11); send_sym(SYNC);
    send_trits(fa, 0, 11); send_sym(SYNC);

    // Reset mid-frame at trit 7.
    send_trits(fa, 0, 6);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_D", D, 4'd0);
    chk("midrst_dv", dv, 1'b0);
    chk("midrst_ok", frame_ok, 1'b0);
    chk("midrst_err", frame_err, 1'b0);
    reset = 1'b0;
    model_reset();
    send_trits(fa, 7, 11); send_sym(SYNC);
    send_trits(fa, 0, 11); send_sym(SYNC);

    // Randomized frames with assorted corruptions.
    rd = 4'd0;
    a  = 16'd0;
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 0) begin
        for (int k = 0; k < 8; k++) a[2*k +: 2] = rtrit();
        addr_i = a;
        m_addr = a;
      end
      if ($urandom_range(3) == 0) rd = 4'($urandom_range(15));
      f = mk_frame(a, rd);
      kind = $urandom_range(7);
      pos  = $urandom_range(11);
      if (kind == 1) begin
        t  = f[2*pos[2:0] +: 2];
        nt = rtrit();
        if (nt == t) nt = (t == 2'b00) ? 2'b11 : 2'b00;
        f[2*pos[2:0] +: 2] = nt;
      end else if (kind == 2) begin
        f[16 + 2*pos[1:0] +: 2] = 2'b10;
      end
      if ($urandom_range(4) == 0) send_sym(SYNC);
      if (kind == 3) begin
        send_trits(f, 0, pos);
        send_sym(SYNC);
        send_trits(f, 0, 11);
      end else if (kind == 4) begin
        send_trits(f, 0, pos);
        send_sym(rtrit(), 1'b1, 1'($urandom_range(1)));
      end else if (kind == 5) begin
        send_trits(f, 0, 11);
        send_sym(rtrit());
      end else begin
        send_trits(f, 0, 11);
      end
      send_sym(SYNC);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
